uart_tx_param: RTL

Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It accepts words over a valid/ready write port into an internal FIFO and serialises them LSB-first onto `Tx`. Frames carry a start bit, a configurable data width, optional parity and 1 or 2 stop bits. Queued words go out back-to-back with no idle gap between frames. It sits between the host/bus logic and the serial pin, and is driven at the system clock.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_fifo.sv | 64 ++++++
 rtl/uart_tx_param.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
// Optional parity support is compiled in with the UART_TX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Parity over the low nbits of data; odd=1 gives odd parity, odd=0 even parity.
  function automatic logic calc_parity(input logic [8:0] data, input int nbits, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) begin
        p = p ^ data[i];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO feeding the UART transmitter.
// Synchronous active-low reset; full/empty flags come from the registered count,
// so a pop in the same cycle never opens a slot for a simultaneous push.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_COUNT);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array: written on every accepted push.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered, LSB-first, 1 or 2 stop bits,
// back-to-back frames. Define UART_TX_PARITY_EN to add a parity bit and the
// parity_odd port. Tx is registered one cycle behind the FSM state, so a word
// pushed at edge E drives the start bit from edge E+2 and TX_Done lines up with
// the last clock of the final stop bit on the wire.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  output logic                          wr_ready,
  input  logic [DATA_BITS-1:0]          in_data,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          Tx,
  output logic                          TX_Done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  uart_tx_state_t         state_r;
  logic [CW-1:0]          cnt_r;
  logic [BW-1:0]          bit_r;
  logic                   stop_r;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   tx_r;
  logic                   done_r;
  logic                   busy_r;
`ifdef UART_TX_PARITY_EN
  logic                   parity_r;
`endif

  logic                   pop_s;
  logic                   tx_level_s;
  logic                   cnt_wrap_s;
  logic                   frame_end_s;
  logic [DATA_BITS-1:0]   fifo_rdata_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (pop_s),
    .wdata (in_data),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count)
  );

  assign wr_ready    = !fifo_full_s;
  assign Tx          = tx_r;
  assign TX_Done     = done_r;
  assign busy        = busy_r;
  assign cnt_wrap_s  = (cnt_r == CNT_LAST);
  assign frame_end_s = (state_r == STOP) && cnt_wrap_s && (stop_r == STOP_LAST);

  // Pop a word when idle, or on the last stop clock to chain the next frame.
  always_comb begin
    pop_s = 1'b0;
    if (state_r == IDLE) begin
      pop_s = !fifo_empty_s;
    end else if (frame_end_s) begin
      pop_s = !fifo_empty_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Line level implied by the current FSM state.
  always_comb begin
    tx_level_s = UART_IDLE_LEVEL;
    case (state_r)
      IDLE:    tx_level_s = UART_IDLE_LEVEL;
      START:   tx_level_s = UART_START_LEVEL;
      DATA:    tx_level_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_level_s = parity_r;
`endif
      STOP:    tx_level_s = UART_IDLE_LEVEL;
      default: tx_level_s = UART_IDLE_LEVEL;
    endcase
  end

  // Frame sequencer: bit timing, shifting, word loading and completion pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      bit_r    <= '0;
      stop_r   <= 1'b0;
      shift_r  <= '0;
      done_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (!fifo_empty_s) begin
            shift_r  <= fifo_rdata_s;
`ifdef UART_TX_PARITY_EN
            parity_r <= calc_parity(9'(fifo_rdata_s), DATA_BITS, parity_odd);
`endif
            state_r  <= START;
          end
        end
        START: begin
          if (cnt_wrap_s) begin
            cnt_r   <= '0;
            bit_r   <= '0;
            state_r <= DATA;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (cnt_wrap_s) begin
            cnt_r   <= '0;
            shift_r <= shift_r >> 1;
            if (bit_r == BIT_LAST) begin
              bit_r   <= '0;
              stop_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
              state_r <= PARITY;
`else
              state_r <= STOP;
`endif
            end else begin
              bit_r <= bit_r + BW'(1);
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cnt_wrap_s) begin
            cnt_r   <= '0;
            stop_r  <= 1'b0;
            state_r <= STOP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt_wrap_s) begin
            cnt_r <= '0;
            if (stop_r == STOP_LAST) begin
              stop_r <= 1'b0;
              done_r <= 1'b1;
              if (!fifo_empty_s) begin
                shift_r  <= fifo_rdata_s;
`ifdef UART_TX_PARITY_EN
                parity_r <= calc_parity(9'(fifo_rdata_s), DATA_BITS, parity_odd);
`endif
                state_r  <= START;
              end else begin
                state_r <= IDLE;
              end
            end else begin
              stop_r <= stop_r + 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Registered line driver and activity flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_r   <= UART_IDLE_LEVEL;
      busy_r <= 1'b0;
    end else begin
      tx_r   <= tx_level_s;
      busy_r <= (state_r != IDLE) || !fifo_empty_s;
    end
  end

endmodule
